reg_file_sb: RTL and testbench

Parametrised multi-ported register file for the ProtoCore datapath: two read ports and one write port, generalised in data width and depth. It adds a synchronous clear, an optional hard-wired zero register, write-to-read bypass, an optional registered-read mode, and a per-register busy scoreboard that lets the pipeline stall on operands still in flight. It sits between decode (ra/rb, reservation) and writeback (wa/wd/we).

---
 rtl/reg_file_sb.sv | 138 +++++++++++++
 tb/tb_reg_file_sb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb : 2R/1W register file with bypass and busy scoreboard         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic              we_ok;
    logic              rsv_ok;
    logic [DATA_W-1:0] read_a_d;
    logic [DATA_W-1:0] read_b_d;
    logic              busy_a_d;
    logic              busy_b_d;

    // Register 0 swallows writes and reservations when hard-wired to zero.
    always_comb begin
        we_ok  = we;
        rsv_ok = rsv_en;
        if (ZERO_REG != 0) begin
            if (wa == '0) begin
                we_ok = 1'b0;
            end
            if (rsv_addr == '0) begin
                rsv_ok = 1'b0;
            end
        end
    end

    // Reserve is applied after the write so a same-address producer stays busy.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we_ok) begin
            mem_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        read_a_d = mem_q[ra];
        busy_a_d = busy_q[ra];
        read_b_d = mem_q[rb];
        busy_b_d = busy_q[rb];
        if ((BYPASS != 0) && we_ok && (wa == ra)) begin
            read_a_d = wd;
            busy_a_d = rsv_ok && (rsv_addr == ra);
        end
        if ((BYPASS != 0) && we_ok && (wa == rb)) begin
            read_b_d = wd;
            busy_b_d = rsv_ok && (rsv_addr == rb);
        end
        if ((ZERO_REG != 0) && (ra == '0)) begin
            read_a_d = '0;
            busy_a_d = 1'b0;
        end
        if ((ZERO_REG != 0) && (rb == '0)) begin
            read_b_d = '0;
            busy_b_d = 1'b0;
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] read_a_q;
            logic [DATA_W-1:0] read_b_q;
            logic              busy_a_q;
            logic              busy_b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    read_a_q <= '0;
                    read_b_q <= '0;
                    busy_a_q <= 1'b0;
                    busy_b_q <= 1'b0;
                end else begin
                    read_a_q <= read_a_d;
                    read_b_q <= read_b_d;
                    busy_a_q <= busy_a_d;
                    busy_b_q <= busy_b_d;
                end
            end

            assign read_a = read_a_q;
            assign read_b = read_b_q;
            assign busy_a = busy_a_q;
            assign busy_b = busy_b_q;
        end else begin : g_read_comb
            assign read_a = read_a_d;
            assign read_b = read_b_d;
            assign busy_a = busy_a_d;
            assign busy_b = busy_b_d;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_file_sb : scoreboard bench over four parameterisations of the RF   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_reg_file_sb;

    typedef struct packed {
        logic        busy;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] ra = '0, rb = '0, wa = '0, rsv_addr = '0;
    logic [7:0] wd = '0;
    logic       we = 1'b0, rsv_en = 1'b0;

    logic [4:0]  r_ra = '0, r_rb = '0, r_wa = '0, r_rsv_addr = '0;
    logic [15:0] r_wd = '0;
    logic        r_we = 1'b0, r_rsv_en = 1'b0;

    logic [7:0]  d_read_a, d_read_b, n_read_a, n_read_b, z_read_a, z_read_b;
    logic        d_busy_a, d_busy_b, n_busy_a, n_busy_b, z_busy_a, z_busy_b;
    logic [15:0] r_read_a, r_read_b;
    logic        r_busy_a, r_busy_b;

    reg_file_sb dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read_a(d_read_a), .read_b(d_read_b), .busy_a(d_busy_a), .busy_b(d_busy_b)
    );

    reg_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read_a(n_read_a), .read_b(n_read_b), .busy_a(n_busy_a), .busy_b(n_busy_b)
    );

    reg_file_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .wa(wa), .wd(wd), .we(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .read_a(z_read_a), .read_b(z_read_b), .busy_a(z_busy_a), .busy_b(z_busy_b)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(5), .READ_REG(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .ra(r_ra), .rb(r_rb), .wa(r_wa), .wd(r_wd), .we(r_we),
        .rsv_en(r_rsv_en), .rsv_addr(r_rsv_addr),
        .read_a(r_read_a), .read_b(r_read_b), .busy_a(r_busy_a), .busy_b(r_busy_b)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t e;
    exp_t got;

    function automatic void push(input logic b, input logic [15:0] d);
        exp_t x;
        x.busy = b;
        x.data = d;
        sb.push_back(x);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = 1'b0;
        rsv_en   = 1'b0;
        r_we     = 1'b0;
        r_rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        push(1'b0, 16'h0000);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_a;
        got.data = r_read_a;
        n_checks++;
        if (got !== e) $display("FAIL reset_regd: got %h want %h", got, e);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            ra = 4'(i);
            rb = 4'(15 - i);
            push(1'b0, 16'h0000);
            push(1'b0, 16'h0000);
            @(negedge clk);
            e = sb.pop_front();
            got.busy = d_busy_a;
            got.data = {8'h00, d_read_a};
            n_checks++;
            if (got !== e) $display("FAIL reset_a[%0d]: got %h want %h", i, got, e);
            else n_pass++;
            e = sb.pop_front();
            got.busy = d_busy_b;
            got.data = {8'h00, d_read_b};
            n_checks++;
            if (got !== e) $display("FAIL reset_b[%0d]: got %h want %h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            we = 1'b1;
            wa = 4'(i);
            wd = 8'(i * 8'h11);
        end
        next_cycle();
        idle();
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            rb = 4'(15 - i);
            push(1'b0, {8'h00, 8'(i * 8'h11)});
            push(1'b0, {8'h00, 8'((15 - i) * 8'h11)});
            @(negedge clk);
            e = sb.pop_front();
            got.busy = d_busy_a;
            got.data = {8'h00, d_read_a};
            n_checks++;
            if (got !== e) $display("FAIL fill_a[%0d]: got %h want %h", i, got, e);
            else n_pass++;
            e = sb.pop_front();
            got.busy = d_busy_b;
            got.data = {8'h00, d_read_b};
            n_checks++;
            if (got !== e) $display("FAIL fill_b[%0d]: got %h want %h", i, got, e);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_bypass();
        we = 1'b1;
        wa = 4'd3;
        wd = 8'hAA;
        ra = 4'd3;
        push(1'b0, 16'h00AA);
        push(1'b0, 16'h0033);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = d_busy_a;
        got.data = {8'h00, d_read_a};
        n_checks++;
        if (got !== e) $display("FAIL bypass_same: got %h want %h", got, e);
        else n_pass++;
        e = sb.pop_front();
        got.busy = n_busy_a;
        got.data = {8'h00, n_read_a};
        n_checks++;
        if (got !== e) $display("FAIL nobypass_old: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
        idle();
        push(1'b0, 16'h00AA);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = n_busy_a;
        got.data = {8'h00, n_read_a};
        n_checks++;
        if (got !== e) $display("FAIL nobypass_next: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_scoreboard();
        // Each row: stimulus for one cycle, then expected port A / port B
        logic [3:0]  t_ra  [7] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd7, 4'd7, 4'd8};
        logic [3:0]  t_rb  [7] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd7, 4'd7, 4'd9};
        logic        t_we  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  t_wa  [7] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd7, 4'd0, 4'd0};
        logic [7:0]  t_wd  [7] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h77, 8'h00, 8'h00};
        logic        t_rv  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  t_rva [7] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0};
        logic        t_ba  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  t_da  [7] = '{8'h55, 8'h55, 8'h5A, 8'h5A, 8'h77, 8'h77, 8'h80};
        logic        t_bb  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0]  t_db  [7] = '{8'h55, 8'h55, 8'h5A, 8'h5A, 8'h77, 8'h77, 8'h99};
        for (int i = 0; i < 7; i++) begin
            ra       = t_ra[i];
            rb       = t_rb[i];
            we       = t_we[i];
            wa       = t_wa[i];
            wd       = t_wd[i];
            rsv_en   = t_rv[i];
            rsv_addr = t_rva[i];
            // Row 5 also writes r8 and reserves r9 on the same edge
            if (i == 5) begin
                we       = 1'b1;
                wa       = 4'd8;
                wd       = 8'h80;
                rsv_en   = 1'b1;
                rsv_addr = 4'd9;
            end
            push(t_ba[i], {8'h00, t_da[i]});
            push(t_bb[i], {8'h00, t_db[i]});
            @(negedge clk);
            e = sb.pop_front();
            got.busy = d_busy_a;
            got.data = {8'h00, d_read_a};
            n_checks++;
            if (got !== e) $display("FAIL sb_a[%0d]: got %h want %h", i, got, e);
            else n_pass++;
            e = sb.pop_front();
            got.busy = d_busy_b;
            got.data = {8'h00, d_read_b};
            n_checks++;
            if (got !== e) $display("FAIL sb_b[%0d]: got %h want %h", i, got, e);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_zero_reg();
        for (int c = 0; c < 2; c++) begin
            ra       = 4'd0;
            rb       = 4'd0;
            we       = (c == 0);
            wa       = 4'd0;
            wd       = 8'hFF;
            rsv_en   = (c == 0);
            rsv_addr = 4'd0;
            push(1'b0, 16'h0000);
            push(1'b1, 16'h00FF);
            @(negedge clk);
            e = sb.pop_front();
            got.busy = z_busy_a;
            got.data = {8'h00, z_read_a};
            n_checks++;
            if (got !== e) $display("FAIL zero_reg[%0d]: got %h want %h", c, got, e);
            else n_pass++;
            e = sb.pop_front();
            got.busy = d_busy_b;
            got.data = {8'h00, d_read_b};
            n_checks++;
            if (got !== e) $display("FAIL nonzero_r0[%0d]: got %h want %h", c, got, e);
            else n_pass++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_registered();
        r_we = 1'b1;
        r_wa = 5'd31;
        r_wd = 16'hBEEF;
        r_ra = 5'd0;
        next_cycle();
        r_we = 1'b0;
        r_ra = 5'd31;
        push(1'b0, 16'h0000);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_a;
        got.data = r_read_a;
        n_checks++;
        if (got !== e) $display("FAIL regd_early: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
        r_we       = 1'b1;
        r_wa       = 5'd10;
        r_wd       = 16'h1234;
        r_ra       = 5'd10;
        r_rsv_en   = 1'b1;
        r_rsv_addr = 5'd20;
        r_rb       = 5'd20;
        push(1'b0, 16'hBEEF);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_a;
        got.data = r_read_a;
        n_checks++;
        if (got !== e) $display("FAIL regd_one: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
        idle();
        push(1'b0, 16'h1234);
        push(1'b0, 16'h0000);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_a;
        got.data = r_read_a;
        n_checks++;
        if (got !== e) $display("FAIL regd_bypass: got %h want %h", got, e);
        else n_pass++;
        e = sb.pop_front();
        got.busy = r_busy_b;
        got.data = r_read_b;
        n_checks++;
        if (got !== e) $display("FAIL regd_busy0: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
        push(1'b1, 16'h0000);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_b;
        got.data = r_read_b;
        n_checks++;
        if (got !== e) $display("FAIL regd_busy1: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        we       = 1'b1;
        wa       = 4'd2;
        wd       = 8'h22;
        rsv_en   = 1'b1;
        rsv_addr = 4'd9;
        next_cycle();
        idle();
        ra = 4'd2;
        rb = 4'd9;
        push(1'b0, 16'h0022);
        push(1'b1, 16'h0099);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = d_busy_a;
        got.data = {8'h00, d_read_a};
        n_checks++;
        if (got !== e) $display("FAIL premid_r2: got %h want %h", got, e);
        else n_pass++;
        e = sb.pop_front();
        got.busy = d_busy_b;
        got.data = {8'h00, d_read_b};
        n_checks++;
        if (got !== e) $display("FAIL premid_r9: got %h want %h", got, e);
        else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        we    = 1'b1;
        wa    = 4'd4;
        wd    = 8'h44;
        next_cycle();
        rst_n = 1'b1;
        idle();
        push(1'b0, 16'h0000);
        @(negedge clk);
        e = sb.pop_front();
        got.busy = r_busy_a;
        got.data = r_read_a;
        n_checks++;
        if (got !== e) $display("FAIL mid_regd: got %h want %h", got, e);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            ra = (k == 0) ? 4'd2 : ((k == 1) ? 4'd4 : 4'd9);
            push(1'b0, 16'h0000);
            @(negedge clk);
            e = sb.pop_front();
            got.busy = d_busy_a;
            got.data = {8'h00, d_read_a};
            n_checks++;
            if (got !== e) $display("FAIL mid_rst[%0d]: got %h want %h", k, got, e);
            else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        test_reset();
        next_cycle();
        test_fill();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_registered();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
